// File: rtl/axi_burst_driver.sv
// Single-outstanding AXI4 INCR burst master: one request becomes one checked burst and one done pulse.
// Latency: read len=0 with ready slaves gives done 4 cycles after request acceptance; W/R beats are pass-through.
// Backpressure: W follows wr_valid/WREADY, R follows rd_ready; new requests are held off until DONE completes.
module axi_burst_driver #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MAX_BEATS      = 16,
    parameter int TXN_ID         = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_is_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [7:0]                  req_len,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] wr_strb,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rd_data,
    output logic                        rd_last,
    output logic                        done_valid,
    output logic [1:0]                  done_resp,
    output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                        M_AXI_AWVALID,
    output logic [AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [1:0]                  M_AXI_AWBURST,
    output logic [2:0]                  M_AXI_AWSIZE,
    output logic [7:0]                  M_AXI_AWLEN,
    input  logic                        M_AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                        M_AXI_WVALID,
    output logic                        M_AXI_WLAST,
    input  logic                        M_AXI_WREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    input  logic                        M_AXI_BVALID,
    input  logic [AXI_ID_WIDTH-1:0]     M_AXI_BID,
    output logic                        M_AXI_BREADY,
    output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                        M_AXI_ARVALID,
    output logic [AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [1:0]                  M_AXI_ARBURST,
    output logic [2:0]                  M_AXI_ARSIZE,
    output logic [7:0]                  M_AXI_ARLEN,
    input  logic                        M_AXI_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    input  logic [AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic                        M_AXI_RLAST,
    output logic                        M_AXI_RREADY
);
    localparam int SIZE = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [AXI_ID_WIDTH-1:0]   ID         = AXI_ID_WIDTH'(TXN_ID);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'((1 << SIZE) - 1);

    typedef enum logic [2:0] {IDLE, CHECK, ADDR, WDATA, BRESP, RDATA, DRAIN, DONE} state_t;

    state_t                      state, state_nxt;
    logic                        is_write, is_write_nxt;
    logic [AXI_ADDR_WIDTH-1:0]   addr, addr_nxt;
    logic [7:0]                  len, len_nxt;
    logic [7:0]                  beat_cnt, beat_cnt_nxt;
    logic [1:0]                  resp, resp_nxt;
    logic                        live;
    logic                        beat_final;
    logic [31:0]                 end_off;
    logic                        reject;
    logic [1:0]                  r_code;

    assign beat_final = (beat_cnt == len);
    // Byte offset one past the burst end within its 4 KB page.
    assign end_off    = 32'(addr[11:0]) + ((32'(len) + 32'd1) << SIZE);
    assign reject     = (int'(len) >= MAX_BEATS) || (end_off > 32'd4096);
    assign r_code     = (M_AXI_RID != ID) ? 2'b10 : (M_AXI_RRESP[1] ? M_AXI_RRESP : 2'b00);

    assign M_AXI_AWADDR  = addr;
    assign M_AXI_AWID    = ID;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWSIZE  = 3'(SIZE);
    assign M_AXI_AWLEN   = len;
    assign M_AXI_ARADDR  = addr;
    assign M_AXI_ARID    = ID;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARSIZE  = 3'(SIZE);
    assign M_AXI_ARLEN   = len;
    assign M_AXI_WDATA   = wr_data;
    assign M_AXI_WSTRB   = wr_strb;
    assign rd_data       = M_AXI_RDATA;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            is_write <= 1'b0;
            addr     <= '0;
            len      <= '0;
            beat_cnt <= '0;
            resp     <= 2'b00;
            live     <= 1'b0;
        end else begin
            state    <= state_nxt;
            is_write <= is_write_nxt;
            addr     <= addr_nxt;
            len      <= len_nxt;
            beat_cnt <= beat_cnt_nxt;
            resp     <= resp_nxt;
            live     <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        is_write_nxt  = is_write;
        addr_nxt      = addr;
        len_nxt       = len;
        beat_cnt_nxt  = beat_cnt;
        resp_nxt      = resp;
        req_ready     = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WLAST   = 1'b0;
        wr_ready      = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_RREADY  = 1'b0;
        rd_valid      = 1'b0;
        rd_last       = 1'b0;
        done_valid    = 1'b0;
        done_resp     = 2'b00;
        case (state)
            IDLE: begin
                // live keeps req_ready low until the first edge after reset release
                req_ready = live;
                if (req_valid && live) begin
                    is_write_nxt = req_is_write;
                    addr_nxt     = req_addr & ALIGN_MASK;
                    len_nxt      = req_len;
                    beat_cnt_nxt = '0;
                    resp_nxt     = 2'b00;
                    state_nxt    = CHECK;
                end
            end
            CHECK: begin
                if (reject) begin
                    resp_nxt  = 2'b10;
                    state_nxt = DONE;
                end else begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (is_write) begin
                    M_AXI_AWVALID = 1'b1;
                    if (M_AXI_AWREADY) state_nxt = WDATA;
                end else begin
                    M_AXI_ARVALID = 1'b1;
                    if (M_AXI_ARREADY) state_nxt = RDATA;
                end
            end
            WDATA: begin
                M_AXI_WVALID = wr_valid;
                wr_ready     = M_AXI_WREADY;
                M_AXI_WLAST  = beat_final;
                if (wr_valid && M_AXI_WREADY) begin
                    beat_cnt_nxt = beat_cnt + 8'd1;
                    if (beat_final) state_nxt = BRESP;
                end
            end
            BRESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    resp_nxt  = (M_AXI_BID != ID) ? 2'b10 : M_AXI_BRESP;
                    state_nxt = DONE;
                end
            end
            RDATA: begin
                M_AXI_RREADY = rd_ready;
                rd_valid     = M_AXI_RVALID;
                rd_last      = beat_final || M_AXI_RLAST;
                if (M_AXI_RVALID && rd_ready) begin
                    beat_cnt_nxt = beat_cnt + 8'd1;
                    if (resp == 2'b00) resp_nxt = r_code;
                    // Any disagreement between our count and the slave's RLAST is a slave error.
                    if (!beat_final && M_AXI_RLAST) begin
                        resp_nxt  = 2'b10;
                        state_nxt = DONE;
                    end else if (beat_final) begin
                        if (!M_AXI_RLAST) begin
                            resp_nxt  = 2'b10;
                            state_nxt = DRAIN;
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end
            end
            DRAIN: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID && M_AXI_RLAST) state_nxt = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                done_resp  = resp;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_burst_driver.sv
// Bench for axi_burst_driver: directed vector table, reset sequences, then randomized bursts vs. a burst-level model.
module tb_axi_burst_driver;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid, req_ready, req_is_write;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic [7:0]    wr_strb;
    logic          rd_valid, rd_ready, rd_last;
    logic [DW-1:0] rd_data;
    logic          done_valid;
    logic [1:0]    done_resp;
    logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic [IW-1:0] M_AXI_AWID, M_AXI_ARID, M_AXI_BID, M_AXI_RID;
    logic [1:0]    M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
    logic [2:0]    M_AXI_AWSIZE, M_AXI_ARSIZE;
    logic [7:0]    M_AXI_AWLEN, M_AXI_ARLEN;
    logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [7:0]    M_AXI_WSTRB;
    logic          M_AXI_WVALID, M_AXI_WLAST, M_AXI_WREADY;
    logic          M_AXI_BVALID, M_AXI_BREADY;
    logic          M_AXI_RVALID, M_AXI_RLAST, M_AXI_RREADY;

    always #5 clk = ~clk;

    axi_burst_driver #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                       .MAX_BEATS(16), .TXN_ID(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_resp(done_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWID(M_AXI_AWID),
        .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BID(M_AXI_BID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARID(M_AXI_ARID),
        .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // One burst scenario: request, slave behaviour (rbeats = beat carrying RLAST), expected outcome.
    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [7:0]  len;
        int          rbeats;
        int          ea;
        logic [1:0]  ca;
        int          eb;
        logic [1:0]  cb;
        logic        exok;
        logic [1:0]  bresp;
        logic        bad_id;
        int          smode;
        int          rmode;
        logic [31:0] seed;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [7:0] l, input int rb,
                                input int ea, input logic [1:0] ca, input int eb, input logic [1:0] cb,
                                input logic [1:0] br, input logic bid, input int sm, input int rm,
                                input logic [1:0] er, input int lat);
        vec_t v;
        v.is_write = w; v.addr = a; v.len = l; v.rbeats = rb;
        v.ea = ea; v.ca = ca; v.eb = eb; v.cb = cb; v.exok = 1'b0;
        v.bresp = br; v.bad_id = bid; v.smode = sm; v.rmode = rm;
        v.seed = a ^ 32'h1357_9bdf ^ 32'(l);
        v.exp_resp = er; v.exp_lat = lat;
        return v;
    endfunction

    function automatic logic [63:0] wpat(input vec_t v, input int i);
        return {v.seed, 24'h0, 8'(i)};
    endfunction
    function automatic logic [7:0] spat(input int i);
        return 8'(i * 37 + 1);
    endfunction
    function automatic logic [63:0] rpat(input vec_t v, input int i);
        return {~v.seed, 24'h5a5a5a, 8'(i)};
    endfunction
    function automatic logic [1:0] rresp_of(input vec_t v, input int i);
        if (i == v.ea) return v.ca;
        if (i == v.eb) return v.cb;
        return v.exok ? 2'b01 : 2'b00;
    endfunction
    function automatic logic rnd(input int mode);
        return (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    // Burst-level reference: page/length rule, then the outcome the slave's behaviour implies.
    function automatic bit is_reject(input vec_t v);
        int off;
        off = int'(v.addr[11:3]) * 8;
        return (int'(v.len) >= 16) || (off + (int'(v.len) + 1) * 8 > 4096);
    endfunction
    function automatic logic [1:0] model_resp(input vec_t v);
        logic [1:0] c;
        if (is_reject(v)) return 2'b10;
        if (v.is_write) return v.bad_id ? 2'b10 : v.bresp;
        if (v.rbeats != int'(v.len) + 1) return 2'b10;
        for (int i = 0; i <= int'(v.len); i++) begin
            c = v.bad_id ? 2'b10 : rresp_of(v, i);
            if (c[1]) return c;
        end
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        req_valid = 0; req_is_write = 0; req_addr = '0; req_len = '0;
        wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
        M_AXI_AWREADY = 0; M_AXI_ARREADY = 0; M_AXI_WREADY = 0;
        M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_BID = 0;
        M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RRESP = 0; M_AXI_RID = 0; M_AXI_RLAST = 0;
    endtask

    // Entered #1 after a rising edge with the DUT idle; samples on falling edges, drives after rising edges.
    task automatic run_txn(input vec_t v, input string nm);
        int cyc, acc_cyc, done_cyc, n_done, ax_seen, ax_bad;
        int w_cnt, w_bad, r_cnt, r_bad, rr_bad, r_sent, exp_n;
        bit acc, ar_ok, w_hs, r_hs, b_hs, b_done, fin;
        logic [1:0]  got;
        logic [31:0] al;
        al = v.addr & ~32'd7;
        exp_n = (v.rbeats < int'(v.len) + 1) ? v.rbeats : int'(v.len) + 1;
        cyc = 0; acc_cyc = 0; done_cyc = 0; n_done = 0; ax_seen = 0; ax_bad = 0;
        w_cnt = 0; w_bad = 0; r_cnt = 0; r_bad = 0; rr_bad = 0; r_sent = 0;
        acc = 0; ar_ok = 0; b_done = 0; fin = 0; got = 2'b00;
        idle_inputs();
        req_valid = 1; req_is_write = v.is_write; req_addr = v.addr; req_len = v.len;
        wr_data = wpat(v, 0); wr_strb = spat(0); rd_ready = 1;
        M_AXI_AWREADY = rnd(v.smode); M_AXI_ARREADY = rnd(v.smode); M_AXI_WREADY = rnd(v.smode);
        M_AXI_BRESP = v.bresp; M_AXI_BID = v.bad_id ? 4'd1 : 4'd0; M_AXI_RID = M_AXI_BID;
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            if (req_valid && req_ready) begin acc = 1; acc_cyc = cyc; end
            if (M_AXI_AWVALID || M_AXI_ARVALID) ax_seen++;
            if (M_AXI_AWVALID && M_AXI_AWREADY && (!v.is_write || M_AXI_AWADDR != al || M_AXI_AWLEN != v.len ||
                M_AXI_AWSIZE != 3'd3 || M_AXI_AWBURST != 2'b01 || M_AXI_AWID != 4'd0)) ax_bad++;
            if (M_AXI_ARVALID && M_AXI_ARREADY && (v.is_write || M_AXI_ARADDR != al || M_AXI_ARLEN != v.len ||
                M_AXI_ARSIZE != 3'd3 || M_AXI_ARBURST != 2'b01 || M_AXI_ARID != 4'd0)) ax_bad++;
            if (ar_ok && r_cnt < exp_n && n_done == 0 && M_AXI_RREADY != rd_ready) rr_bad++;
            if (M_AXI_ARVALID && M_AXI_ARREADY) ar_ok = 1;
            w_hs = M_AXI_WVALID && M_AXI_WREADY;
            if (w_hs) begin
                if (M_AXI_WDATA != wpat(v, w_cnt) || M_AXI_WSTRB != spat(w_cnt) ||
                    M_AXI_WLAST != (w_cnt == int'(v.len))) w_bad++;
                w_cnt++;
            end
            b_hs = M_AXI_BVALID && M_AXI_BREADY;
            if (rd_valid && rd_ready) begin
                if (rd_data != rpat(v, r_cnt) || rd_last != (r_cnt == exp_n - 1)) r_bad++;
                r_cnt++;
            end
            r_hs = M_AXI_RVALID && M_AXI_RREADY;
            if (done_valid) begin n_done++; got = done_resp; done_cyc = cyc; end
            if (n_done > 0 && cyc >= done_cyc + 3) fin = 1;
            @(posedge clk); #1;
            cyc++;
            if (acc) req_valid = 0;
            if (!(wr_valid && !w_hs))
                wr_valid = v.is_write && (w_cnt <= int'(v.len)) && rnd(v.smode);
            wr_data = wpat(v, w_cnt); wr_strb = spat(w_cnt);
            if (b_hs) b_done = 1;
            if (!(M_AXI_BVALID && !b_hs))
                M_AXI_BVALID = !b_done && (w_cnt == int'(v.len) + 1) && rnd(v.smode);
            if (r_hs) r_sent++;
            if (!(M_AXI_RVALID && !r_hs))
                M_AXI_RVALID = ar_ok && (r_sent < v.rbeats) && rnd(v.smode);
            M_AXI_RDATA = rpat(v, r_sent); M_AXI_RRESP = rresp_of(v, r_sent);
            M_AXI_RLAST = (r_sent == v.rbeats - 1);
            M_AXI_AWREADY = rnd(v.smode); M_AXI_ARREADY = rnd(v.smode); M_AXI_WREADY = rnd(v.smode);
            case (v.rmode)
                0:       rd_ready = 1;
                1:       rd_ready = ~rd_ready;
                default: rd_ready = rnd(1);
            endcase
        end
        idle_inputs();
        chk($sformatf("%s completed in budget", nm), fin, 1);
        chk($sformatf("%s done pulses", nm), n_done, 1);
        chk($sformatf("%s done_resp", nm), got, v.exp_resp);
        if (v.exp_lat >= 0) chk($sformatf("%s req-to-done cycles", nm), done_cyc - acc_cyc, v.exp_lat);
        if (is_reject(v)) begin
            chk($sformatf("%s address-phase cycles", nm), ax_seen, 0);
        end else begin
            chk($sformatf("%s bad address beats", nm), ax_bad, 0);
            if (v.is_write) begin
                chk($sformatf("%s W beats", nm), w_cnt, int'(v.len) + 1);
                chk($sformatf("%s bad W beats", nm), w_bad, 0);
            end else begin
                chk($sformatf("%s rd beats", nm), r_cnt, exp_n);
                chk($sformatf("%s bad rd beats", nm), r_bad, 0);
                chk($sformatf("%s RREADY mirror errors", nm), rr_bad, 0);
            end
        end
    endtask

    initial begin
        vec_t tbl[12];
        vec_t v;
        int   wc, nd;
        bit   acc;

        tbl[0]  = mk(1, 32'h100, 3, 4, -1, 0, -1, 0, 2'b00, 0, 0, 0, 2'b00, -1);
        tbl[1]  = mk(0, 32'h040, 7, 8, -1, 0, -1, 0, 2'b00, 0, 0, 1, 2'b00, -1);
        tbl[2]  = mk(0, 32'h080, 7, 8, 2, 2'b10, 4, 2'b11, 2'b00, 0, 1, 2, 2'b10, -1);
        tbl[3]  = mk(1, 32'h000, 16, 17, -1, 0, -1, 0, 2'b00, 0, 0, 0, 2'b10, 2);
        tbl[4]  = mk(0, 32'hfc0, 15, 16, -1, 0, -1, 0, 2'b00, 0, 0, 0, 2'b10, 2);
        tbl[5]  = mk(0, 32'h200, 3, 2, -1, 0, -1, 0, 2'b00, 0, 0, 0, 2'b10, -1);
        tbl[6]  = mk(0, 32'h300, 1, 4, -1, 0, -1, 0, 2'b00, 0, 0, 0, 2'b10, -1);
        tbl[7]  = mk(0, 32'h000, 0, 1, -1, 0, -1, 0, 2'b00, 0, 0, 0, 2'b00, 4);
        tbl[8]  = mk(1, 32'h500, 2, 3, -1, 0, -1, 0, 2'b00, 1, 1, 0, 2'b10, -1);
        tbl[9]  = mk(1, 32'h600, 0, 1, -1, 0, -1, 0, 2'b11, 0, 1, 0, 2'b11, -1);
        tbl[10] = mk(0, 32'hf84, 15, 16, -1, 0, -1, 0, 2'b00, 0, 1, 2, 2'b00, -1);
        tbl[11] = mk(0, 32'h700, 3, 4, -1, 0, -1, 0, 2'b00, 0, 1, 2, 2'b00, -1);
        tbl[11].exok = 1'b1;

        // Reset: inputs driven active so that any ungated pass-through would show.
        idle_inputs();
        wr_valid = 1; M_AXI_WREADY = 1; rd_ready = 1; M_AXI_RVALID = 1; M_AXI_RLAST = 1;
        M_AXI_BVALID = 1; req_valid = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", req_ready, 0);
        chk("reset AWVALID|ARVALID", M_AXI_AWVALID | M_AXI_ARVALID, 0);
        chk("reset WVALID|wr_ready", M_AXI_WVALID | wr_ready, 0);
        chk("reset BREADY|RREADY", M_AXI_BREADY | M_AXI_RREADY, 0);
        chk("reset rd_valid|rd_last", rd_valid | rd_last, 0);
        chk("reset done_valid", done_valid, 0);
        chk("reset done_resp", done_resp, 0);
        idle_inputs();
        rst_n = 1;
        @(posedge clk); @(negedge clk);
        chk("req_ready after reset release", req_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted while beat 2 of a write burst is on the W channel.
        idle_inputs();
        req_valid = 1; req_is_write = 1; req_addr = 32'h200; req_len = 3;
        wr_valid = 1; wr_data = 64'h1111; wr_strb = 8'hff; M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
        wc = 0; acc = 0;
        for (int n = 0; n < 50 && wc < 1; n++) begin
            @(negedge clk);
            if (req_valid && req_ready) acc = 1;
            if (M_AXI_WVALID && M_AXI_WREADY) wc++;
            @(posedge clk); #1;
            if (acc) req_valid = 0;
        end
        chk("midburst reached beat 2", wc, 1);
        chk("midburst WVALID before reset", M_AXI_WVALID, 1);
        rst_n = 0;
        #1;
        chk("midburst WVALID after reset", M_AXI_WVALID, 0);
        chk("midburst AWVALID after reset", M_AXI_AWVALID, 0);
        chk("midburst wr_ready after reset", wr_ready, 0);
        nd = 0;
        repeat (2) begin @(negedge clk); if (done_valid) nd++; end
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); @(negedge clk);
        chk("midburst req_ready after release", req_ready, 1);
        repeat (4) begin @(negedge clk); if (done_valid) nd++; end
        chk("midburst done pulses", nd, 0);
        @(posedge clk); #1;
        run_txn(mk(0, 32'h800, 2, 3, -1, 0, -1, 0, 2'b00, 0, 0, 0, 2'b00, -1), "post-reset read");

        // Randomized bursts checked against the burst-level model.
        for (int i = 0; i < 40; i++) begin
            v = mk(1'($urandom_range(0, 1)), $urandom_range(0, 8191), 8'($urandom_range(0, 17)),
                   0, -1, 0, -1, 0, 2'b00, 0, 1, $urandom_range(0, 2), 2'b00, -1);
            v.rbeats = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(v.len) + 3) : int'(v.len) + 1;
            if ($urandom_range(0, 2) == 0) v.ea = $urandom_range(0, int'(v.len));
            if ($urandom_range(0, 2) == 0) v.eb = $urandom_range(0, int'(v.len));
            v.ca = 2'($urandom_range(2, 3));
            v.cb = 2'($urandom_range(2, 3));
            v.exok = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       v.bresp = 2'b00;
                1:       v.bresp = 2'b10;
                default: v.bresp = 2'b11;
            endcase
            v.bad_id = ($urandom_range(0, 7) == 0);
            v.seed = $urandom;
            v.exp_resp = model_resp(v);
            v.exp_lat = is_reject(v) ? 2 : -1;
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
